// File: rtl/vga_scanout_gen.sv
// VGA raster generator with double-buffered line fetch and registered outputs.
// Define VGA_SCAN_DOUBLE_EN to fetch half-width lines and show each one on two lines.
module vga_scanout_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 4,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter logic [3*COLOR_W-1:0] FG_RGB = '1,
  parameter logic [3*COLOR_W-1:0] BG_RGB = '0,
`ifdef VGA_SCAN_DOUBLE_EN
  localparam int LW = H_ACTIVE / 2
`else
  localparam int LW = H_ACTIVE
`endif
) (
  input  logic               VGAClock,
  input  logic               VGAReset_n,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               LINE_REQ,
  output logic [15:0]        LINE_SEQ,
  input  logic [LW-1:0]      LINE,
  input  logic               LINE_VALID,
  output logic               FRAME_READY,
  output logic               UNDERRUN,
  output logic [15:0]        H_POS,
  output logic [15:0]        V_POS
);

  localparam int IW = (LW > 1) ? $clog2(LW) : 1;
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0]          h_q, h_d, v_q, v_d;
  logic [LW-1:0]        shadow_q, shadow_d, disp_q, disp_d;
  logic                 req_q, req_d, filled_q, filled_d;
  logic [15:0]          seq_q, seq_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 hs_q, hs_d, vs_q, vs_d, fr_q, fr_d, under_q, under_d;
  logic [15:0]          hpos_q, hpos_d, vpos_q, vpos_d;

  logic [IW-1:0] pixIdx;
  logic [15:0]   vNext, nextSeq;
  logic          wantReq, fillNow;

  assign vNext   = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
  assign fillNow = req_q && LINE_VALID;

  // Doubled scan: only even display lines are fetched, odd lines repeat them.
`ifdef VGA_SCAN_DOUBLE_EN
  assign pixIdx  = IW'(h_q >> 1);
  assign wantReq = (h_q == H_ACT) && (vNext < V_ACT) && !vNext[0];
  assign nextSeq = {1'b0, vNext[15:1]};
`else
  assign pixIdx  = IW'(h_q);
  assign wantReq = (h_q == H_ACT) && (vNext < V_ACT);
  assign nextSeq = vNext;
`endif

  always_comb begin
    h_d      = (h_q == H_LAST) ? 16'd0 : h_q + 16'd1;
    v_d      = v_q;
    hpos_d   = h_q;
    vpos_d   = v_q;
    hs_d     = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs_d     = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
    fr_d     = (v_q >= V_ACT);
    rgb_d    = '0;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    req_d    = req_q;
    filled_d = filled_q;
    seq_d    = seq_q;
    under_d  = 1'b0;

    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
    end
    if (h_q < H_ACT && v_q < V_ACT) begin
      rgb_d = disp_q[pixIdx] ? FG_RGB : BG_RGB;
    end
    if (fillNow) begin
      shadow_d = LINE;
      filled_d = 1'b1;
      req_d    = 1'b0;
    end
    // End of line: an outstanding request still open here is either met this cycle or missed.
    if (h_q == H_LAST) begin
      if (filled_q) begin
        disp_d = shadow_q;
      end else if (req_q) begin
        if (LINE_VALID) begin
          disp_d = LINE;
        end else begin
          disp_d  = '0;
          under_d = 1'b1;
        end
      end
      req_d    = 1'b0;
      filled_d = 1'b0;
    end
    if (wantReq) begin
      req_d    = 1'b1;
      filled_d = 1'b0;
      seq_d    = nextSeq;
    end
  end

  always_ff @(posedge VGAClock or negedge VGAReset_n) begin
    if (!VGAReset_n) begin
      h_q      <= '0;
      v_q      <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      req_q    <= 1'b0;
      filled_q <= 1'b0;
      seq_q    <= '0;
      rgb_q    <= '0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      fr_q     <= 1'b0;
      under_q  <= 1'b0;
      hpos_q   <= '0;
      vpos_q   <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      req_q    <= req_d;
      filled_q <= filled_d;
      seq_q    <= seq_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fr_q     <= fr_d;
      under_q  <= under_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
    end
  end

  assign VGA_R       = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B       = rgb_q[COLOR_W-1:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign LINE_REQ    = req_q;
  assign LINE_SEQ    = seq_q;
  assign FRAME_READY = fr_q;
  assign UNDERRUN    = under_q;
  assign H_POS       = hpos_q;
  assign V_POS       = vpos_q;

endmodule

// File: tb/tb_vga_scanout_gen.sv
// Bench for vga_scanout_gen on a tiny 14x7 raster; honours VGA_SCAN_DOUBLE_EN like the design.
// A transaction-level raster model predicts every output; two instances cover both sync polarities.
module tb_vga_scanout_gen;

  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW = 4;
  localparam logic [3*CW-1:0] FG = 12'hFFF;
  localparam logic [3*CW-1:0] BG = 12'h000;
`ifdef VGA_SCAN_DOUBLE_EN
  localparam bit DOUBLE = 1'b1;
  localparam int LW = H_ACTIVE / 2;
  localparam logic [LW-1:0] PATTERN = 4'b0011;
`else
  localparam bit DOUBLE = 1'b0;
  localparam int LW = H_ACTIVE;
  localparam logic [LW-1:0] PATTERN = 8'hA5;
`endif

  logic          VGAClock = 1'b0;
  logic          VGAReset_n = 1'b1;
  logic          lineValid = 1'b0;
  logic [LW-1:0] lineData = '0;

  logic [CW-1:0] r0, g0, b0, r1, g1, b1;
  logic          hs0, vs0, req0, fr0, ur0, hs1, vs1, req1, fr1, ur1;
  logic [15:0]   seq0, hp0, vp0, seq1, hp1, vp1;

  int assertCount = 0;
  int failCount = 0;
  int phase = 0;
  int urCount = 0;
  bit checking = 1'b0;

  // Model state: cycle index since reset release plus the line held for display.
  int            cyc, mh, mv, t;
  logic [LW-1:0] curLine, nextData;
  bit            issued, filled;
  int            eH, eV, eFrame;
  bit            eHsPulse, eVsPulse, eReq, eFR, eUnder;
  logic [15:0]   eSeq;
  logic [3*CW-1:0] eRgb;

  always #5 VGAClock = ~VGAClock;

  vga_scanout_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COLOR_W(CW), .HS_POL(1'b0), .VS_POL(1'b0), .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .VGAClock(VGAClock), .VGAReset_n(VGAReset_n),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0),
    .LINE_REQ(req0), .LINE_SEQ(seq0), .LINE(lineData), .LINE_VALID(lineValid),
    .FRAME_READY(fr0), .UNDERRUN(ur0), .H_POS(hp0), .V_POS(vp0)
  );

  vga_scanout_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COLOR_W(CW), .HS_POL(1'b1), .VS_POL(1'b1), .FG_RGB(FG), .BG_RGB(BG)
  ) dutInv (
    .VGAClock(VGAClock), .VGAReset_n(VGAReset_n),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
    .LINE_REQ(req1), .LINE_SEQ(seq1), .LINE(lineData), .LINE_VALID(lineValid),
    .FRAME_READY(fr1), .UNDERRUN(ur1), .H_POS(hp1), .V_POS(vp1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Position and polarity follow from the cycle count; pixels from the line fetched for this row.
  always @(posedge VGAClock or negedge VGAReset_n) begin
    if (!VGAReset_n) begin
      cyc = 0; curLine = '0; nextData = '0; issued = 0; filled = 0;
      eH = 0; eV = 0; eFrame = -1; eHsPulse = 0; eVsPulse = 0;
      eReq = 0; eSeq = '0; eFR = 0; eUnder = 0; eRgb = '0;
    end else begin
      mh = cyc % H_TOT;
      mv = (cyc / H_TOT) % V_TOT;
      eH = mh; eV = mv; eFrame = cyc / (H_TOT * V_TOT);
      eHsPulse = (mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC);
      eVsPulse = (mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC);
      eFR = (mv >= V_ACTIVE);
      if (mh < H_ACTIVE && mv < V_ACTIVE)
        eRgb = curLine[DOUBLE ? mh / 2 : mh] ? FG : BG;
      else
        eRgb = '0;
      eUnder = 0;
      if (mh == H_TOT - 1) begin
        if (issued) begin
          if (filled) curLine = nextData;
          else if (lineValid) curLine = lineData;
          else begin curLine = '0; eUnder = 1; end
        end
        issued = 0; filled = 0; eReq = 0;
      end else if (issued && !filled && lineValid) begin
        nextData = lineData; filled = 1; eReq = 0;
      end
      if (mh == H_ACTIVE) begin
        t = (mv + 1) % V_TOT;
        if (t < V_ACTIVE && (!DOUBLE || t % 2 == 0)) begin
          issued = 1; filled = 0; eReq = 1;
          eSeq = 16'(DOUBLE ? t / 2 : t);
        end
      end
      cyc++;
    end
  end

  task automatic checkPins();
    if (phase == 1 && eFrame == 0) begin
      if (eV == 0 && eH == 10) checkOutput("A_hs_low_h10", hs0, 0);
      if (eV == 0 && eH == 11) checkOutput("A_hs_low_h11", hs0, 0);
      if (eV == 0 && eH == 12) checkOutput("A_hs_high_h12", hs0, 1);
      if (eV == 0 && eH == 10) checkOutput("F_hs_inv_h10", hs1, 1);
      if (eV == 0 && eH == 9)  checkOutput("F_hs_inv_h9", hs1, 0);
      if (eV == 5 && eH == 0)  checkOutput("A_vs_low_v5", vs0, 0);
      if (eV == 5 && eH == 0)  checkOutput("F_vs_inv_v5", vs1, 1);
      if (eV == 4 && eH == 0)  checkOutput("A_vs_high_v4", vs0, 1);
      if (eV == 4 && eH == 0)  checkOutput("A_fr_v4", fr0, 1);
      if (eV == 6 && eH == 13) checkOutput("A_fr_v6", fr0, 1);
      if (eV == 3 && eH == 13) checkOutput("A_fr_v3", fr0, 0);
      if (eV == 0 && eH == 0)  checkOutput("A_line0_bg", r0, 0);
`ifdef VGA_SCAN_DOUBLE_EN
      if (eV == 1 && eH == 0)  checkOutput("E_line1_bg", r0, 0);
      if (eV == 2 && eH == 0)  checkOutput("E_l2_x0_fg", r0, 4'hF);
      if (eV == 3 && eH == 3)  checkOutput("E_l3_x3_fg", r0, 4'hF);
      if (eV == 2 && eH == 4)  checkOutput("E_l2_x4_bg", g0, 0);
      if (eV == 3 && eH == 7)  checkOutput("E_l3_x7_bg", b0, 0);
      if (eV == 0 && eH == 8)  checkOutput("E_seq_v0", seq0, 0);
      if (eV == 1 && eH == 8)  checkOutput("E_seq_v1", seq0, 1);
      if (eV == 1 && eH == 8)  checkOutput("E_req_v1", req0, 1);
`else
      if (eV == 1 && eH == 0)  checkOutput("A_l1_x0_fg", r0, 4'hF);
      if (eV == 1 && eH == 5)  checkOutput("A_l1_x5_fg", r0, 4'hF);
      if (eV == 2 && eH == 1)  checkOutput("A_l2_x1_bg", g0, 0);
      if (eV == 3 && eH == 7)  checkOutput("A_l3_x7_fg", b0, 4'hF);
      if (eV == 0 && eH == 8)  checkOutput("A_seq_v0", seq0, 1);
`endif
    end
    if (phase == 2 && eFrame == 0 && eV == (DOUBLE ? 1 : 0)) begin
      if (eH == 12) checkOutput("B_req_h12", req0, 1);
      if (eH == 13) checkOutput("B_req_drop_h13", req0, 0);
      if (eH == 13) checkOutput("B_underrun_h13", ur0, 1);
    end
    if (phase == 3 && eFrame == 0 && eV == 2 && eH == 3)
      checkOutput("C_l2_x3_fg", r0, 4'hF);
  endtask

  always @(negedge VGAClock) begin
    if (checking) begin
      checkOutput("R", r0, eRgb[3*CW-1 -: CW]);
      checkOutput("G", g0, eRgb[2*CW-1 -: CW]);
      checkOutput("B", b0, eRgb[CW-1:0]);
      checkOutput("HS", hs0, eHsPulse ? 0 : 1);
      checkOutput("VS", vs0, eVsPulse ? 0 : 1);
      checkOutput("LINE_REQ", req0, eReq);
      checkOutput("LINE_SEQ", seq0, eSeq);
      checkOutput("FRAME_READY", fr0, eFR);
      checkOutput("UNDERRUN", ur0, eUnder);
      checkOutput("H_POS", hp0, eH);
      checkOutput("V_POS", vp0, eV);
      checkOutput("HS_inv", hs1, eHsPulse ? 1 : 0);
      checkOutput("VS_inv", vs1, eVsPulse ? 1 : 0);
      checkOutput("R_inv", r1, eRgb[3*CW-1 -: CW]);
      checkOutput("UNDERRUN_inv", ur1, eUnder);
      checkPins();
      if (ur0 && eFrame == 0 && eV < V_ACTIVE) urCount++;
    end
  end

  task automatic driveInputs(input int mode);
    case (mode)
      1: begin lineValid = 1'b1; lineData = PATTERN; end
      3: begin lineValid = (cyc % H_TOT == H_TOT - 1); lineData = '1; end
      4: begin lineValid = ($urandom_range(0, 3) == 0); lineData = LW'($urandom); end
      default: begin lineValid = 1'b0; lineData = LW'($urandom); end
    endcase
  endtask

  task automatic applyStimulus(input int mode, input int cycles);
    @(negedge VGAClock);
    #2 VGAReset_n = 1'b0;
    phase = mode;
    urCount = 0;
    repeat (2) @(negedge VGAClock);
    #2 driveInputs(mode);
    VGAReset_n = 1'b1;
    repeat (cycles) begin
      @(negedge VGAClock);
      #1 driveInputs(mode);
    end
  endtask

  initial begin
    #1 VGAReset_n = 1'b0;
    #2;
    checkOutput("RST_req", req0, 0);
    checkOutput("RST_seq", seq0, 0);
    checkOutput("RST_underrun", ur0, 0);
    checkOutput("RST_frame_ready", fr0, 0);
    checkOutput("RST_rgb", {r0, g0, b0}, 0);
    checkOutput("RST_hs", hs0, 1);
    checkOutput("RST_vs", vs0, 1);
    checkOutput("RST_hs_inv", hs1, 0);
    checkOutput("RST_vs_inv", vs1, 0);
    checkOutput("RST_pos", {hp0, vp0}, 0);
    checkOutput("RST_pos_inv", {hp1, vp1}, 0);
    checking = 1'b1;

    applyStimulus(1, 2 * H_TOT * V_TOT);
    applyStimulus(2, 2 * H_TOT * V_TOT);
    checkOutput("B_underrun_count", urCount, DOUBLE ? 1 : 3);
    applyStimulus(3, 2 * H_TOT * V_TOT);
    checkOutput("C_underrun_count", urCount, 0);
    applyStimulus(4, 5 * H_TOT * V_TOT);

    // Abort an open request by asserting reset between clock edges.
    applyStimulus(5, H_ACTIVE + 1);
    checkOutput("D_req_before", req0, DOUBLE ? 0 : 1);
    #1 VGAReset_n = 1'b0;
    #1;
    checkOutput("D_req", req0, 0);
    checkOutput("D_rgb", {r0, g0, b0}, 0);
    checkOutput("D_pos", {hp0, vp0}, 0);
    checkOutput("D_hs", hs0, 1);
    checkOutput("D_vs", vs0, 1);
    checkOutput("D_hs_inv", hs1, 0);
    checkOutput("D_vs_inv", vs1, 0);
    repeat (2) @(negedge VGAClock);

    applyStimulus(4, 2 * H_TOT * V_TOT);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
